// File: rtl/aes_pkg.sv
// AES-128 constants, tables and round primitives shared by the iterative cipher core.
// The inverse primitives are only referenced when AES_DECRYPT_EN is defined.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {StIdle, StRun, StDone} aes_state_e;
  typedef logic [NR:0][BLOCK_W-1:0] rk_array_t;

  localparam logic [NR:1][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  // Byte 0x00 sits in the top 8 bits of each table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte n of the block (column n/4, row n%4) lives at bits [8*(15-n) +: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(15 - (4*c + row)) +: 8] = s[8*(15 - (4*((c + row) % 4) + row)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[8*(15 - (4*((c + row) % 4) + row)) +: 8] = s[8*(15 - (4*c + row)) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  // Pre-multiplying by {04,00,05,00} turns the forward MixColumns into its inverse.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] w);
    logic [7:0] u, v;
    u = xtime(xtime(w[31:24] ^ w[15:8]));
    v = xtime(xtime(w[23:16] ^ w[7:0]));
    return mix_column(w ^ {u, v, u, v});
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = mix_column(s[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry cache.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [127:0]  i_key,
  output rk_array_t     o_round_keys,
  output logic          o_key_ready,
  output logic          o_busy
);

  rk_array_t    r_rk;
  logic [127:0] r_last;
  logic [3:0]   r_cnt;
  logic         r_active;
  logic         r_ready;

  logic [31:0]  w_rot;
  logic [31:0]  w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next;

  assign w_rot  = {r_last[23:0], r_last[31:24]};
  assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                ^ {RCON[r_cnt], 24'h0};
  assign w_n0   = r_last[127:96] ^ w_temp;
  assign w_n1   = r_last[95:64] ^ w_n0;
  assign w_n2   = r_last[63:32] ^ w_n1;
  assign w_n3   = r_last[31:0] ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  // r_cnt runs 1..10 while writing keys; the extra step at 11 raises key_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk     <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_ready  <= 1'b0;
    end else if (i_load) begin
      r_rk[0]  <= i_key;
      r_last   <= i_key;
      r_cnt    <= 4'd1;
      r_active <= 1'b1;
      r_ready  <= 1'b0;
    end else if (r_active) begin
      if (r_cnt == 4'(NR + 1)) begin
        r_active <= 1'b0;
        r_ready  <= 1'b1;
      end else begin
        r_rk[r_cnt] <= w_next;
        r_last      <= w_next;
        r_cnt       <= r_cnt + 4'd1;
      end
    end
  end

  assign o_round_keys = r_rk;
  assign o_key_ready  = r_ready;
  assign o_busy       = r_active;

endmodule

// File: rtl/aes_iter_core.sv
// Handshaked AES-128 core evaluating ROUNDS_PER_CYCLE rounds per clock on a cached key schedule.
// Define AES_DECRYPT_EN to compile in the inverse cipher selected by in_decrypt.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [0:127] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5 ||
        ROUNDS_PER_CYCLE == 10)) begin : g_bad_rounds
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  aes_state_e   r_state, w_state_next;
  logic [3:0]   r_round, w_round_next;
  logic [127:0] r_data, w_data_next;
  logic         r_decrypt, w_decrypt_next;
  logic [127:0] r_out_data, w_out_data_next;
  logic         r_out_valid, w_out_valid_next;

  logic [127:0] w_key;
  logic [127:0] w_in_data;
  logic         w_in_dec;
  logic         w_key_load;
  logic         w_key_ready;
  logic         w_key_busy;
  rk_array_t    w_rk;
  logic [127:0] w_round_out;

  assign w_key      = key;
  assign w_in_data  = in_data;
  assign w_key_load = key_load && (r_state == StIdle);

`ifdef AES_DECRYPT_EN
  assign w_in_dec = in_decrypt;
`else
  logic w_unused_decrypt;
  assign w_in_dec         = 1'b0;
  assign w_unused_decrypt = in_decrypt ^ r_decrypt;
`endif

  aes_key_expand u_key_expand (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_key_load),
    .i_key        (w_key),
    .o_round_keys (w_rk),
    .o_key_ready  (w_key_ready),
    .o_busy       (w_key_busy)
  );

  // Stage g performs round r_round+g+1; encrypt uses that key, decrypt its mirror.
  for (genvar g = 0; g < int'(ROUNDS_PER_CYCLE); g++) begin : g_round
    logic [127:0] w_in;
    logic [127:0] w_out;
    logic [127:0] w_enc;
    logic [3:0]   w_idx;
    logic         w_last;

    if (g == 0) begin : g_first
      assign w_in = r_data;
    end else begin : g_chain
      assign w_in = g_round[g-1].w_out;
    end

    assign w_idx  = r_round + 4'(g + 1);
    assign w_last = (w_idx == 4'(NR));

    always_comb begin
      w_enc = shift_rows(sub_bytes(w_in));
      if (!w_last) w_enc = mix_columns(w_enc);
      w_enc = w_enc ^ w_rk[w_idx];
    end

`ifdef AES_DECRYPT_EN
    logic [127:0] w_dec;
    always_comb begin
      w_dec = inv_sub_bytes(inv_shift_rows(w_in)) ^ w_rk[4'(NR) - w_idx];
      if (!w_last) w_dec = inv_mix_columns(w_dec);
    end
    assign w_out = r_decrypt ? w_dec : w_enc;
`else
    assign w_out = w_enc;
`endif
  end

  assign w_round_out = g_round[ROUNDS_PER_CYCLE-1].w_out;

  always_comb begin
    w_state_next     = r_state;
    w_round_next     = r_round;
    w_data_next      = r_data;
    w_decrypt_next   = r_decrypt;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    unique case (r_state)
      StIdle: begin
        if (in_valid && in_ready) begin
          w_data_next    = w_in_data ^ (w_in_dec ? w_rk[NR] : w_rk[0]);
          w_decrypt_next = w_in_dec;
          w_round_next   = 4'd0;
          w_state_next   = StRun;
        end
      end
      StRun: begin
        if (r_round == 4'(NR)) begin
          w_out_data_next  = r_data;
          w_out_valid_next = 1'b1;
          w_state_next     = StDone;
        end else begin
          w_data_next  = w_round_out;
          w_round_next = r_round + 4'(ROUNDS_PER_CYCLE);
        end
      end
      StDone: begin
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_round     <= '0;
      r_data      <= '0;
      r_decrypt   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_round     <= w_round_next;
      r_data      <= w_data_next;
      r_decrypt   <= w_decrypt_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign key_ready = w_key_ready;
  assign in_ready  = w_key_ready && (r_state == StIdle) && !key_load;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != StIdle) || w_key_busy;

endmodule
